// File: rtl/prog_launcher_if.sv
// Handshake bundle between the run launcher and the host/processor side.
// The launcher drives the processor controls and the run status; the host
// side drives the run request and the processor feeds back its halt flag.
//
// Handshake: Go is a level request sampled only while the launcher is idle.
// A request seen in any other state is dropped, not queued. DutAck is a level
// halt flag sampled only while a run is in progress. Done is a one-cycle
// pulse marking the end of a run. CycleCt and TimedOut are valid from that
// pulse until the next accepted Go.
interface prog_launcher_if #(
    parameter int CW = 16
);
    logic          Go;
    logic          DutAck;
    logic          DutReset;
    logic          DutStart;
    logic          Busy;
    logic          Done;
    logic          TimedOut;
    logic [CW-1:0] CycleCt;
    logic [7:0]    RunCt;

    // Launcher side
    modport master (
        input  Go,
        input  DutAck,
        output DutReset,
        output DutStart,
        output Busy,
        output Done,
        output TimedOut,
        output CycleCt,
        output RunCt
    );

    // Host / processor side
    modport slave (
        output Go,
        output DutAck,
        input  DutReset,
        input  DutStart,
        input  Busy,
        input  Done,
        input  TimedOut,
        input  CycleCt,
        input  RunCt
    );
endinterface

// File: rtl/prog_launcher.sv
// Run launcher for the processor Start/Ack handshake.
// Each run holds the processor in reset, pulses Start, and then counts RUN
// cycles until Ack or timeout. It reports the cycle count, the timeout flag
// and a wrapping count of completed runs. All outputs come from flops.
module prog_launcher #(
    parameter int          RST_CYCLES   = 2,
    parameter int          START_CYCLES = 1,
    parameter int          CW           = 16,
    parameter int unsigned TIMEOUT      = 32'hFFFF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    prog_launcher_if.master      bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One phase counter serves both the RST and the START phase, so it is
    // sized for the longer of the two.
    localparam int PMAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0] RST_LOAD   = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] START_LOAD = PW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TO_FULL    = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);

    state_t        state_q,     state_d;
    logic [PW-1:0] phase_q,     phase_d;
    logic [CW-1:0] cycle_ct_q,  cycle_ct_d;
    logic          timed_out_q, timed_out_d;
    logic [7:0]    run_ct_q,    run_ct_d;
    logic          dut_reset_q, dut_reset_d;
    logic          dut_start_q, dut_start_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    // Next-state, counters and the registered output values.
    // The output flops follow the next state, so each output is high
    // exactly during the cycles its state occupies.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cycle_ct_d  = cycle_ct_q;
        timed_out_d = timed_out_q;
        run_ct_d    = run_ct_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Go) begin
                    phase_d     = RST_LOAD;
                    timed_out_d = 1'b0;
                    state_d     = S_RST;
                end
            end
            S_RST: begin
                if (phase_q == '0) begin
                    phase_d = START_LOAD;
                    state_d = S_START;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_START: begin
                // Ack may still be high from the previous halt, so it is
                // ignored here. The count starts from zero on RUN entry.
                cycle_ct_d = '0;
                if (phase_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            S_RUN: begin
                // Ack wins over a timeout in the same cycle.
                if (bus.DutAck) begin
                    state_d = S_DONE;
                end else if (cycle_ct_q == TO_LAST) begin
                    cycle_ct_d  = TO_FULL;
                    timed_out_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cycle_ct_d = cycle_ct_q + 1'b1;
                end
            end
            S_DONE: begin
                run_ct_d = run_ct_q + 8'd1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        dut_reset_d = (state_d == S_RST);
        dut_start_d = (state_d == S_START);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and output flops. While reset is low the processor
    // is held in reset. IDLE releases it on the first edge afterwards.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            cycle_ct_q  <= '0;
            timed_out_q <= 1'b0;
            run_ct_q    <= 8'd0;
            dut_reset_q <= 1'b1;
            dut_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cycle_ct_q  <= cycle_ct_d;
            timed_out_q <= timed_out_d;
            run_ct_q    <= run_ct_d;
            dut_reset_q <= dut_reset_d;
            dut_start_q <= dut_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.DutReset = dut_reset_q;
    assign bus.DutStart = dut_start_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.TimedOut = timed_out_q;
    assign bus.CycleCt  = cycle_ct_q;
    assign bus.RunCt    = run_ct_q;
    assign state_dbg    = state_q;

endmodule
